// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN stack sequencer.
package rpn_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned OP_WIDTH   = 3;

    localparam logic [OP_WIDTH-1:0] OP_ADD   = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_SUB   = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_MUL   = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_DUP   = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_DROP  = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_SWAP  = 3'd5;
    localparam logic [OP_WIDTH-1:0] OP_PRINT = 3'd6;
    localparam logic [OP_WIDTH-1:0] OP_CLR   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SWAP2 = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational arithmetic on (second, first); results wrap at DATA_WIDTH bits.
module rpn_alu
    import rpn_pkg::*;
(
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] second,
    input  logic [DATA_WIDTH-1:0] first,
    output logic [DATA_WIDTH-1:0] res_c
);

    logic [2*DATA_WIDTH-1:0] prod_c;

    always_comb begin
        prod_c = (2*DATA_WIDTH)'(second) * (2*DATA_WIDTH)'(first);
        res_c  = '0;
        case (op)
            OP_ADD:  res_c = second + first;
            OP_SUB:  res_c = second - first;
            OP_MUL:  res_c = prod_c[DATA_WIDTH-1:0];
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Token sequencer for the operand stack: tracks depth, refuses illegal accesses,
// and issues registered wen/din/pop_cnt commands plus PRINT results.
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int unsigned STACK_ADDR_WIDTH = 5,
    parameter int unsigned MAX_DEPTH        = 2**STACK_ADDR_WIDTH - 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tok_valid,
    output logic                        tok_ready,
    input  logic                        tok_is_op,
    input  logic [OP_WIDTH-1:0]         tok_op,
    input  logic [DATA_WIDTH-1:0]       tok_num,
    output logic                        stk_wen,
    output logic [DATA_WIDTH-1:0]       stk_din,
    output logic [1:0]                  stk_pop_cnt,
    input  logic [DATA_WIDTH-1:0]       stk_first,
    input  logic [DATA_WIDTH-1:0]       stk_second,
    output logic                        res_valid,
    output logic [DATA_WIDTH-1:0]       res_data,
    output logic                        err_pulse,
    output logic                        err_sticky,
    output logic [STACK_ADDR_WIDTH-1:0] depth
);

    localparam int unsigned   AW    = STACK_ADDR_WIDTH;
    localparam logic [AW-1:0] MAX_D = AW'(MAX_DEPTH);
    localparam logic [AW-1:0] ONE   = AW'(1);
    localparam logic [AW-1:0] TWO   = AW'(2);
    localparam logic [AW-1:0] THREE = AW'(3);

    state_e                state_q, state_d;
    logic                  tok_is_op_q, tok_is_op_d;
    logic [OP_WIDTH-1:0]   tok_op_q, tok_op_d;
    logic [DATA_WIDTH-1:0] tok_num_q, tok_num_d;
    logic [DATA_WIDTH-1:0] swap_q, swap_d;
    logic [AW-1:0]         depth_q, depth_d;
    logic                  tok_ready_q, tok_ready_d;
    logic                  stk_wen_q, stk_wen_d;
    logic [DATA_WIDTH-1:0] stk_din_q, stk_din_d;
    logic [1:0]            stk_pop_q, stk_pop_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  err_pulse_q, err_pulse_d;
    logic                  err_sticky_q, err_sticky_d;

    logic                  illegal_c;
    logic [1:0]            clr_pop_c;
    logic [DATA_WIDTH-1:0] alu_res_c;

    rpn_alu u_alu (
        .op     (tok_op_q),
        .second (stk_second),
        .first  (stk_first),
        .res_c  (alu_res_c)
    );

    // Stack commands are decided in EXEC/SWAP2/CLEAR and take effect the following cycle.
    always_comb begin
        state_d      = state_q;
        tok_is_op_d  = tok_is_op_q;
        tok_op_d     = tok_op_q;
        tok_num_d    = tok_num_q;
        swap_d       = swap_q;
        depth_d      = depth_q;
        stk_wen_d    = 1'b0;
        stk_din_d    = '0;
        stk_pop_d    = 2'd0;
        res_valid_d  = 1'b0;
        res_data_d   = res_data_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        illegal_c    = 1'b0;
        clr_pop_c    = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (tok_valid) begin
                    tok_is_op_d = tok_is_op;
                    tok_op_d    = tok_op;
                    tok_num_d   = tok_num;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (!tok_is_op_q) begin
                    if (depth_q < MAX_D) begin
                        stk_wen_d = 1'b1;
                        stk_din_d = tok_num_q;
                        depth_d   = depth_q + ONE;
                    end else begin
                        illegal_c = 1'b1;
                    end
                end else begin
                    case (tok_op_q)
                        OP_ADD, OP_SUB, OP_MUL: begin
                            if (depth_q >= TWO) begin
                                stk_wen_d = 1'b1;
                                stk_pop_d = 2'd2;
                                stk_din_d = alu_res_c;
                                depth_d   = depth_q - ONE;
                            end else begin
                                illegal_c = 1'b1;
                            end
                        end
                        OP_DUP: begin
                            if (depth_q >= ONE && depth_q < MAX_D) begin
                                stk_wen_d = 1'b1;
                                stk_din_d = stk_first;
                                depth_d   = depth_q + ONE;
                            end else begin
                                illegal_c = 1'b1;
                            end
                        end
                        OP_DROP: begin
                            if (depth_q >= ONE) begin
                                stk_pop_d = 2'd1;
                                depth_d   = depth_q - ONE;
                            end else begin
                                illegal_c = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            if (depth_q >= TWO) begin
                                stk_wen_d = 1'b1;
                                stk_pop_d = 2'd2;
                                stk_din_d = stk_first;
                                swap_d    = stk_second;
                                state_d   = ST_SWAP2;
                            end else begin
                                illegal_c = 1'b1;
                            end
                        end
                        OP_PRINT: begin
                            if (depth_q >= ONE) begin
                                res_valid_d = 1'b1;
                                res_data_d  = stk_first;
                            end else begin
                                illegal_c = 1'b1;
                            end
                        end
                        default: begin
                            err_sticky_d = 1'b0;
                            state_d      = ST_CLEAR;
                        end
                    endcase
                end
                if (illegal_c) begin
                    err_pulse_d  = 1'b1;
                    err_sticky_d = 1'b1;
                end
            end
            ST_SWAP2: begin
                stk_wen_d = 1'b1;
                stk_din_d = swap_q;
                state_d   = ST_IDLE;
            end
            default: begin
                // Drain up to three entries per cycle; the last pop returns to IDLE.
                clr_pop_c = (depth_q >= THREE) ? 2'd3 : depth_q[1:0];
                stk_pop_d = clr_pop_c;
                depth_d   = depth_q - AW'(clr_pop_c);
                if (depth_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        tok_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tok_is_op_q  <= 1'b0;
            tok_op_q     <= '0;
            tok_num_q    <= '0;
            swap_q       <= '0;
            depth_q      <= '0;
            tok_ready_q  <= 1'b1;
            stk_wen_q    <= 1'b0;
            stk_din_q    <= '0;
            stk_pop_q    <= 2'd0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tok_is_op_q  <= tok_is_op_d;
            tok_op_q     <= tok_op_d;
            tok_num_q    <= tok_num_d;
            swap_q       <= swap_d;
            depth_q      <= depth_d;
            tok_ready_q  <= tok_ready_d;
            stk_wen_q    <= stk_wen_d;
            stk_din_q    <= stk_din_d;
            stk_pop_q    <= stk_pop_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign tok_ready   = tok_ready_q;
    assign stk_wen     = stk_wen_q;
    assign stk_din     = stk_din_q;
    assign stk_pop_cnt = stk_pop_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign err_pulse   = err_pulse_q;
    assign err_sticky  = err_sticky_q;
    assign depth       = depth_q;

endmodule
